// File: rtl/fifo_sc_fwft_pkg.sv
// Shared derivations and parameter-legality checks for the single-clock FWFT FIFO.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int fill_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Capacity is depth+1 because the output register holds one word beyond the RAM.
  function automatic bit params_ok(input int width, input int depth,
                                   input int afull, input int aempty);
    return (width >= 1) && is_pow2(depth) &&
           (afull >= 1) && (afull <= depth + 1) &&
           (aempty >= 0) && (aempty <= depth);
  endfunction

endpackage

// File: rtl/fifo_sc_fwft_if.sv
// Write-side and read-side handshake bundle of the single-clock FWFT FIFO.
interface fifo_sc_fwft_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_data_valid;
  logic             i_dready;

  modport master (
    output i_data, i_valid, i_dready,
    input  o_ready, o_data, o_data_valid
  );

  modport slave (
    input  i_data, i_valid, i_dready,
    output o_ready, o_data, o_data_valid
  );
endinterface

// File: rtl/fifo_sc_ptr_ctrl.sv
// Pointer, full/empty, fill-level and overflow bookkeeping for fifo_sc_fwft.
// Optional saturating drop counter under FIFO_SC_DROP_CNT_EN.
module fifo_sc_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int PW    = ptr_width(DEPTH),
  localparam int AW    = PW - 1,
  localparam int FW    = fill_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req_i,
  input  logic          load_i,
  input  logic          pop_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          ram_full_o,
  output logic          ram_empty_o,
  output logic [FW-1:0] fill_o,
  output logic          overflow_o
`ifdef FIFO_SC_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt_o
`endif
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          drop;

  assign ram_empty_o = (wr_ptr_q == rd_ptr_q);
  assign ram_full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en_o     = wr_req_i && !ram_full_o;
  assign drop        = wr_req_i && ram_full_o;
  assign wr_addr_o   = wr_ptr_q[AW-1:0];
  assign rd_addr_o   = rd_ptr_q[AW-1:0];
  assign fill_o      = fill_q;
  assign overflow_o  = overflow_q;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch leaves one unassigned and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q | drop;
    if (wr_en_o) wr_ptr_d = wr_ptr_q + PW'(1);
    if (load_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en_o, pop_i})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIFO_SC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: rtl/fifo_sc_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM, output register, threshold flags.
// FIFO_SC_DROP_CNT_EN adds a 16-bit saturating o_drop_cnt of rejected writes.
module fifo_sc_fwft
  import fifo_pkg::*;
#(
  parameter  int INT_FIFO_WIDTH    = 32,
  parameter  int INT_FIFO_DEPTH    = 1024,
  parameter  int INT_AFULL_THRESH  = INT_FIFO_DEPTH - 1,
  parameter  int INT_AEMPTY_THRESH = 1,
  localparam int FW                = fill_width(INT_FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  fifo_sc_fwft_if.slave bus,
  output logic [FW-1:0] o_fill,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic          o_overflow
`ifdef FIFO_SC_DROP_CNT_EN
  ,
  output logic [15:0]   o_drop_cnt
`endif
);

  localparam int AW = ptr_width(INT_FIFO_DEPTH) - 1;
  localparam logic [FW-1:0] AFULL_LVL  = FW'(INT_AFULL_THRESH);
  localparam logic [FW-1:0] AEMPTY_LVL = FW'(INT_AEMPTY_THRESH);

  if (!params_ok(INT_FIFO_WIDTH, INT_FIFO_DEPTH, INT_AFULL_THRESH, INT_AEMPTY_THRESH))
  begin : g_bad_params
    $error("fifo_sc_fwft: illegal width/depth/threshold parameter set");
  end

  logic [INT_FIFO_WIDTH-1:0] mem [INT_FIFO_DEPTH];
  logic [INT_FIFO_WIDTH-1:0] data_q;
  logic                      valid_q, valid_d;
  logic [AW-1:0]             wr_addr, rd_addr;
  logic                      wr_en, ram_full, ram_empty, load, pop;

  // Refill whenever the output register is empty or being consumed this cycle.
  assign load = (!valid_q || bus.i_dready) && !ram_empty;
  assign pop  = valid_q && bus.i_dready;

  fifo_sc_ptr_ctrl #(
    .DEPTH (INT_FIFO_DEPTH)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr_req_i    (bus.i_valid),
    .load_i      (load),
    .pop_i       (pop),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .rd_addr_o   (rd_addr),
    .ram_full_o  (ram_full),
    .ram_empty_o (ram_empty),
    .fill_o      (o_fill),
    .overflow_o  (o_overflow)
`ifdef FIFO_SC_DROP_CNT_EN
    ,
    .drop_cnt_o  (o_drop_cnt)
`endif
  );

  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; the pointers alone decide which entries are live.
    if (wr_en) mem[wr_addr] <= bus.i_data;
  end

  always_comb begin
    valid_d = valid_q;
    if (load)     valid_d = 1'b1;
    else if (pop) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) data_q <= mem[rd_addr];
    end
  end

  assign bus.o_ready      = !ram_full;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign o_almost_full    = (o_fill >= AFULL_LVL);
  assign o_almost_empty   = (o_fill <= AEMPTY_LVL);

endmodule

// File: tb/tb_fifo_sc_fwft.sv
// Directed and scoreboard bench for fifo_sc_fwft (DEPTH=8 default thresholds, DEPTH=16 AFULL=14 AEMPTY=2).
module tb_fifo_sc_fwft;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  fifo_sc_fwft_if #(.WIDTH(32)) b8  ();
  fifo_sc_fwft_if #(.WIDTH(32)) b16 ();

  logic [3:0] fill8;
  logic [4:0] fill16;
  logic       afull8, aempty8, ovf8, afull16, aempty16, ovf16;
`ifdef FIFO_SC_DROP_CNT_EN
  logic [15:0] drop8, drop16;
`endif

  fifo_sc_fwft #(
    .INT_FIFO_WIDTH (32),
    .INT_FIFO_DEPTH (8)
  ) dut8 (
    .clk            (clk),
    .rst            (rst),
    .bus            (b8),
    .o_fill         (fill8),
    .o_almost_full  (afull8),
    .o_almost_empty (aempty8),
    .o_overflow     (ovf8)
`ifdef FIFO_SC_DROP_CNT_EN
    ,
    .o_drop_cnt     (drop8)
`endif
  );

  fifo_sc_fwft #(
    .INT_FIFO_WIDTH    (32),
    .INT_FIFO_DEPTH    (16),
    .INT_AFULL_THRESH  (14),
    .INT_AEMPTY_THRESH (2)
  ) dut16 (
    .clk            (clk),
    .rst            (rst),
    .bus            (b16),
    .o_fill         (fill16),
    .o_almost_full  (afull16),
    .o_almost_empty (aempty16),
    .o_overflow     (ovf16)
`ifdef FIFO_SC_DROP_CNT_EN
    ,
    .o_drop_cnt     (drop16)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b8.i_valid = 1'b0;  b8.i_dready = 1'b0;  b8.i_data = '0;
    b16.i_valid = 1'b0; b16.i_dready = 1'b0; b16.i_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (b8.o_ready !== 1'b1)      begin n_err++; $display("FAIL rst_ready got %b want 1", b8.o_ready); end
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", b8.o_data_valid); end
    n_cmp++; if (b8.o_data !== 32'h0)      begin n_err++; $display("FAIL rst_data got %h want 0", b8.o_data); end
    n_cmp++; if (fill8 !== 4'd0)           begin n_err++; $display("FAIL rst_fill got %0d want 0", fill8); end
    n_cmp++; if (ovf8 !== 1'b0)            begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf8); end
    n_cmp++; if (aempty8 !== 1'b1)         begin n_err++; $display("FAIL rst_aempty got %b want 1", aempty8); end
    n_cmp++; if (afull8 !== 1'b0)          begin n_err++; $display("FAIL rst_afull got %b want 0", afull8); end
`ifdef FIFO_SC_DROP_CNT_EN
    n_cmp++; if (drop8 !== 16'd0)          begin n_err++; $display("FAIL rst_drop got %0d want 0", drop8); end
`endif
  endtask

  task automatic test_first_word();
    do_reset();
    b8.i_data = 32'hA5A5A5A5; b8.i_valid = 1'b1;
    tick();
    b8.i_valid = 1'b0;
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL fw_valid_e0 got %b want 0", b8.o_data_valid); end
    n_cmp++; if (fill8 !== 4'd1)           begin n_err++; $display("FAIL fw_fill_e0 got %0d want 1", fill8); end
    tick();
    n_cmp++; if (b8.o_data_valid !== 1'b1)    begin n_err++; $display("FAIL fw_valid_e1 got %b want 1", b8.o_data_valid); end
    n_cmp++; if (b8.o_data !== 32'hA5A5A5A5)  begin n_err++; $display("FAIL fw_data_e1 got %h want a5a5a5a5", b8.o_data); end
    n_cmp++; if (fill8 !== 4'd1)              begin n_err++; $display("FAIL fw_fill_e1 got %0d want 1", fill8); end
    n_cmp++; if (aempty8 !== 1'b1)            begin n_err++; $display("FAIL fw_aempty got %b want 1", aempty8); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b8.i_data = 32'(i); b8.i_valid = 1'b1;
      n_cmp++; if (b8.o_ready !== (i < 9)) begin n_err++; $display("FAIL ov_ready[%0d] got %b want %b", i, b8.o_ready, (i < 9)); end
      tick();
    end
    b8.i_valid = 1'b0;
    n_cmp++; if (fill8 !== 4'd9)   begin n_err++; $display("FAIL ov_fill got %0d want 9", fill8); end
    n_cmp++; if (ovf8 !== 1'b1)    begin n_err++; $display("FAIL ov_flag got %b want 1", ovf8); end
    n_cmp++; if (afull8 !== 1'b1)  begin n_err++; $display("FAIL ov_afull got %b want 1", afull8); end
    n_cmp++; if (aempty8 !== 1'b0) begin n_err++; $display("FAIL ov_aempty got %b want 0", aempty8); end
`ifdef FIFO_SC_DROP_CNT_EN
    n_cmp++; if (drop8 !== 16'd1)  begin n_err++; $display("FAIL ov_drop got %0d want 1", drop8); end
`endif
    b8.i_dready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      n_cmp++; if (b8.o_data_valid !== 1'b1) begin n_err++; $display("FAIL dr_valid[%0d] got %b want 1", k, b8.o_data_valid); end
      n_cmp++; if (b8.o_data !== 32'(k))     begin n_err++; $display("FAIL dr_data[%0d] got %0d want %0d", k, b8.o_data, k); end
      tick();
    end
    b8.i_dready = 1'b0;
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL dr_valid_end got %b want 0", b8.o_data_valid); end
    n_cmp++; if (fill8 !== 4'd0)           begin n_err++; $display("FAIL dr_fill_end got %0d want 0", fill8); end
    n_cmp++; if (ovf8 !== 1'b1)            begin n_err++; $display("FAIL dr_ovf_sticky got %b want 1", ovf8); end
  endtask

  // Steady state holds one word in RAM and one in the output register, so fill sits at 2.
  task automatic test_back_to_back();
    do_reset();
    b8.i_dready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b8.i_data = 32'(100 + i); b8.i_valid = 1'b1;
      tick();
      n_cmp++; if (b8.o_ready !== 1'b1) begin n_err++; $display("FAIL bb_ready[%0d] got %b want 1", i, b8.o_ready); end
      n_cmp++; if (fill8 !== ((i == 0) ? 4'd1 : 4'd2)) begin n_err++; $display("FAIL bb_fill[%0d] got %0d want %0d", i, fill8, (i == 0) ? 1 : 2); end
      if (i >= 1) begin
        n_cmp++; if (b8.o_data_valid !== 1'b1)    begin n_err++; $display("FAIL bb_valid[%0d] got %b want 1", i, b8.o_data_valid); end
        n_cmp++; if (b8.o_data !== 32'(99 + i))  begin n_err++; $display("FAIL bb_data[%0d] got %0d want %0d", i, b8.o_data, 99 + i); end
      end
    end
    b8.i_valid = 1'b0;
    tick();
    n_cmp++; if (b8.o_data !== 32'd139) begin n_err++; $display("FAIL bb_last got %0d want 139", b8.o_data); end
    n_cmp++; if (fill8 !== 4'd1)        begin n_err++; $display("FAIL bb_fill_tail got %0d want 1", fill8); end
    tick();
    b8.i_dready = 1'b0;
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL bb_valid_end got %b want 0", b8.o_data_valid); end
    n_cmp++; if (fill8 !== 4'd0)           begin n_err++; $display("FAIL bb_fill_end got %0d want 0", fill8); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          m_ram = 0, m_fill = 0, popped = 0, cycles = 0;
    bit          m_valid = 1'b0, v, d, wr, rd, ld;
    logic [31:0] wdata;
    do_reset();
    while (popped < 10000) begin
      if (cycles >= 60000) begin
        n_cmp++; n_err++; $display("FAIL rnd_timeout popped %0d want 10000", popped);
        break;
      end
      n_cmp++; if (fill16 !== 5'(m_fill))        begin n_err++; $display("FAIL rnd_fill@%0d got %0d want %0d", cycles, fill16, m_fill); end
      n_cmp++; if (b16.o_ready !== (m_ram < 16))  begin n_err++; $display("FAIL rnd_ready@%0d got %b want %b", cycles, b16.o_ready, (m_ram < 16)); end
      n_cmp++; if (b16.o_data_valid !== m_valid)  begin n_err++; $display("FAIL rnd_valid@%0d got %b want %b", cycles, b16.o_data_valid, m_valid); end
      n_cmp++; if (afull16 !== (m_fill >= 14))    begin n_err++; $display("FAIL rnd_afull@%0d got %b want %b", cycles, afull16, (m_fill >= 14)); end
      n_cmp++; if (aempty16 !== (m_fill <= 2))    begin n_err++; $display("FAIL rnd_aempty@%0d got %b want %b", cycles, aempty16, (m_fill <= 2)); end
      if (m_valid) begin
        n_cmp++; if (b16.o_data !== q[0]) begin n_err++; $display("FAIL rnd_data@%0d got %h want %h", cycles, b16.o_data, q[0]); end
      end
      v = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      wdata = $urandom;
      b16.i_valid = v; b16.i_dready = d; b16.i_data = wdata;
      wr = v && (m_ram < 16);
      rd = m_valid && d;
      ld = (!m_valid || d) && (m_ram > 0);
      if (rd) begin void'(q.pop_front()); popped++; end
      if (wr) q.push_back(wdata);
      m_ram   = m_ram + int'(wr) - int'(ld);
      m_fill  = m_fill + int'(wr) - int'(rd);
      m_valid = ld ? 1'b1 : (rd ? 1'b0 : m_valid);
      tick();
      cycles++;
    end
    b16.i_valid = 1'b0; b16.i_dready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b8.i_data = 32'h50 + 32'(i); b8.i_valid = 1'b1;
      tick();
    end
    n_cmp++; if (fill8 !== 4'd5) begin n_err++; $display("FAIL mr_fill_pre got %0d want 5", fill8); end
    rst = 1'b1; b8.i_data = 32'hDEAD; b8.i_valid = 1'b1;
    tick();
    rst = 1'b0; b8.i_valid = 1'b0;
    n_cmp++; if (fill8 !== 4'd0)           begin n_err++; $display("FAIL mr_fill got %0d want 0", fill8); end
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid got %b want 0", b8.o_data_valid); end
    n_cmp++; if (ovf8 !== 1'b0)            begin n_err++; $display("FAIL mr_ovf got %b want 0", ovf8); end
    n_cmp++; if (b8.o_ready !== 1'b1)      begin n_err++; $display("FAIL mr_ready got %b want 1", b8.o_ready); end
    tick();
    n_cmp++; if (b8.o_data_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid_idle got %b want 0", b8.o_data_valid); end
    b8.i_data = 32'h1234; b8.i_valid = 1'b1;
    tick();
    b8.i_valid = 1'b0;
    tick();
    n_cmp++; if (b8.o_data_valid !== 1'b1) begin n_err++; $display("FAIL mr_new_valid got %b want 1", b8.o_data_valid); end
    n_cmp++; if (b8.o_data !== 32'h1234)   begin n_err++; $display("FAIL mr_new_data got %h want 1234", b8.o_data); end
    n_cmp++; if (fill8 !== 4'd1)           begin n_err++; $display("FAIL mr_new_fill got %0d want 1", fill8); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b8.i_data = 32'h60 + 32'(i); b8.i_valid = 1'b1;
      tick();
    end
    n_cmp++; if (b8.o_ready !== 1'b0) begin n_err++; $display("FAIL fr_ready_full got %b want 0", b8.o_ready); end
    n_cmp++; if (ovf8 !== 1'b0)       begin n_err++; $display("FAIL fr_ovf_pre got %b want 0", ovf8); end
    n_cmp++; if (fill8 !== 4'd9)      begin n_err++; $display("FAIL fr_fill_pre got %0d want 9", fill8); end
    b8.i_data = 32'hBAD; b8.i_valid = 1'b1; b8.i_dready = 1'b1;
    tick();
    b8.i_valid = 1'b0; b8.i_dready = 1'b0;
    n_cmp++; if (ovf8 !== 1'b1)          begin n_err++; $display("FAIL fr_ovf got %b want 1", ovf8); end
    n_cmp++; if (b8.o_ready !== 1'b1)    begin n_err++; $display("FAIL fr_ready got %b want 1", b8.o_ready); end
    n_cmp++; if (fill8 !== 4'd8)         begin n_err++; $display("FAIL fr_fill got %0d want 8", fill8); end
    n_cmp++; if (b8.o_data !== 32'h61)   begin n_err++; $display("FAIL fr_head got %h want 61", b8.o_data); end
`ifdef FIFO_SC_DROP_CNT_EN
    n_cmp++; if (drop8 !== 16'd1)        begin n_err++; $display("FAIL fr_drop got %0d want 1", drop8); end
`endif
    b8.i_dready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      n_cmp++; if (b8.o_data !== 32'h60 + 32'(k)) begin n_err++; $display("FAIL fr_drain[%0d] got %h want %h", k, b8.o_data, 32'h60 + k); end
      tick();
    end
    b8.i_dready = 1'b0;
    n_cmp++; if (fill8 !== 4'd0) begin n_err++; $display("FAIL fr_fill_end got %0d want 0", fill8); end
  endtask

  initial begin
    b8.i_valid = 1'b0;  b8.i_dready = 1'b0;  b8.i_data = '0;
    b16.i_valid = 1'b0; b16.i_dready = 1'b0; b16.i_data = '0;
    tick();
    test_reset();
    test_first_word();
    test_fill_overflow();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_full_rw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
